alu_mul_seq: RTL and testbench

//  Iterative shift-add sequencer computing the low WIDTH bits of a*b (RISC-V MUL).

---
 rtl/alu_mul_seq_if.sv | 32 +++
 rtl/alu_mul_seq.sv | 119 +++++++++++
 tb/tb_alu_mul_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/alu_mul_seq_if.sv
// Shared-ALU request port of the iterative multiplier.
// master: sequencer side, slave: arbiter/ALU side.
`ifndef ALU_ADD
`define ALU_ADD 4'b0001
`endif

interface alu_mul_seq_if;
  logic        alu_req;
  logic        alu_gnt;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_c;

  modport master (
    output alu_req,
    output alu_a,
    output alu_b,
    output alu_op,
    input  alu_gnt,
    input  alu_c
  );

  modport slave (
    input  alu_req,
    input  alu_a,
    input  alu_b,
    input  alu_op,
    output alu_gnt,
    output alu_c
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add MUL sequencer borrowing the pipeline ALU for adds.
// Ports: clk_i/rst_i, start/flush, operands, busy/done/result, alu (master).
`ifndef ALU_ADD
`define ALU_ADD 4'b0001
`endif

module alu_mul_seq #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  alu_mul_seq_if.master    alu
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             step;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    step        = 1'b0;
    done_o      = 1'b0;
    alu.alu_req = 1'b0;
    alu.alu_a   = '0;
    alu.alu_b   = '0;
    alu.alu_op  = 4'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          mcand_d  = op_a_i;
          mplier_d = op_b_i;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (EARLY_EXIT && mplier_q == '0) begin
          state_d = DONE;
        end else if (mplier_q[0]) begin
          alu.alu_req = 1'b1;
          alu.alu_a   = acc_q;
          alu.alu_b   = mcand_q;
          alu.alu_op  = `ALU_ADD;
          if (alu.alu_gnt) begin
            acc_d = alu.alu_c;
            step  = 1'b1;
          end
        end else begin
          step = 1'b1;
        end
        if (step) begin
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = DONE;
        end
      end
      DONE: begin
        done_o   = 1'b1;
        result_d = acc_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result is forwarded combinationally in DONE so EX sees it with done_o.
  assign result_o = (state_q == DONE) ? acc_q : result_q;
  assign busy_o   = (state_q == RUN) || (state_q == DONE);

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with an adder model as ALU.
// Second instance runs with EARLY_EXIT=0.
`ifndef ALU_ADD
`define ALU_ADD 4'b0001
`endif

module tb_alu_mul_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy0, done0, busy1, done1;
  logic [31:0] res0, res1;
  logic        gnt0 = 1'b1;

  int checks = 0;
  int errors = 0;

  alu_mul_seq_if if0 ();
  alu_mul_seq_if if1 ();

  assign if0.alu_gnt = gnt0;
  assign if0.alu_c   = if0.alu_a + if0.alu_b;
  assign if1.alu_gnt = 1'b1;
  assign if1.alu_c   = if1.alu_a + if1.alu_b;

  alu_mul_seq #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
    .op_a_i(op_a), .op_b_i(op_b), .busy_o(busy0), .done_o(done0),
    .result_o(res0), .alu(if0.master)
  );

  alu_mul_seq #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
    .op_a_i(op_a), .op_b_i(op_b), .busy_o(busy1), .done_o(done1),
    .result_o(res1), .alu(if1.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int stall,
                        output int dcyc, output int dcyc1,
                        output logic [31:0] r, output logic [31:0] r1,
                        output int reqs, output logic [63:0] mask,
                        output logic zbad, output logic sbad,
                        output logic dup, output logic bsy1);
    dcyc = -1; dcyc1 = -1; r = '0; r1 = '0; reqs = 0; mask = '0;
    zbad = 1'b0; sbad = 1'b0; dup = 1'b0; bsy1 = 1'b0;
    start = 1'b1; op_a = a; op_b = b;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      gnt0 = (cyc <= stall) ? 1'b0 : 1'b1;
      #1;
      if (cyc == 1) bsy1 = busy0;
      if (done0) begin
        if (dcyc < 0) dcyc = cyc; else dup = 1'b1;
        r = res0;
      end
      if (done1 && dcyc1 < 0) begin
        dcyc1 = cyc;
        r1 = res1;
      end
      if (if0.alu_req) begin
        reqs++;
        mask[cyc] = 1'b1;
      end else if ((if0.alu_a | if0.alu_b) != 0 || if0.alu_op != 0) begin
        zbad = 1'b1;
      end
      if (cyc <= stall && !(if0.alu_req && if0.alu_a == 0 &&
          if0.alu_b == a && if0.alu_op == `ALU_ADD))
        sbad = 1'b1;
    end
    gnt0 = 1'b1;
  endtask

  int d, d1, rq;
  logic [31:0] r, r1;
  logic [63:0] m;
  logic zb, sb, dp, b1, seen;

  initial begin
    // Reset state
    #2 rst = 1'b1;
    #1;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_result", res0, 0);
    check("rst_req", if0.alu_req, 0);
    check("rst_alu_ab", {if0.alu_a, if0.alu_b}, 0);
    check("rst_alu_op", if0.alu_op, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // 3*5: adds in cycles 1 and 3, done at 5
    run_op(32'd3, 32'd5, 0, d, d1, r, r1, rq, m, zb, sb, dp, b1);
    check("m35_busy", b1, 1);
    check("m35_done_cyc", d, 5);
    check("m35_result", r, 15);
    check("m35_req_mask", m, 64'hA);
    check("m35_zero_ops", zb, 0);
    check("m35_single_done", dp, 0);
    check("m35_result_held", res0, 15);

    // all-ones squared, full 32 steps
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, d, d1, r, r1, rq, m, zb, sb,
           dp, b1);
    check("mff_done_cyc", d, 33);
    check("mff_result", r, 1);
    check("mff_reqs", rq, 32);
    check("mff_zero_ops", zb, 0);

    // b=0, both instances idle first
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!busy1 && !busy0) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("idle_wait", seen, 1);
    run_op(32'h1234, 32'h0, 0, d, d1, r, r1, rq, m, zb, sb, dp, b1);
    check("mb0_done_cyc", d, 2);
    check("mb0_result", r, 0);
    check("mb0_reqs", rq, 0);
    check("mb0_noee_done_cyc", d1, 33);
    check("mb0_noee_result", r1, 0);

    // 7*3 with gnt low 10 cycles on the first add
    run_op(32'd7, 32'd3, 10, d, d1, r, r1, rq, m, zb, sb, dp, b1);
    check("m73_done_cyc", d, 14);
    check("m73_result", r, 21);
    check("m73_stall_stable", sb, 0);
    check("m73_zero_ops", zb, 0);

    // flush at cycle 5; start at cycle 3 ignored
    seen = 1'b0;
    start = 1'b1; op_a = 32'd5; op_b = 32'hFFFF_FFFF;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == 3);
      flush = (cyc == 5);
      if (cyc == 3) op_b = 32'd1;
      #1;
      if (done0) seen = 1'b1;
      if (cyc == 4) check("fl_busy_c4", busy0, 1);
      if (cyc == 6) check("fl_idle_c6", busy0, 0);
    end
    start = 1'b0; flush = 1'b0;
    check("fl_no_done", seen, 0);
    check("fl_result_kept", res0, 21);

    // start with flush in IDLE is ignored
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    #1 check("fl_start_ignored", busy0, 0);

    // async reset mid-RUN
    start = 1'b1; op_a = 32'h10; op_b = 32'hFFFF_FFFF;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 check("ar_req_before", if0.alu_req, 1);
    rst = 1'b1;
    #1;
    check("ar_busy", busy0, 0);
    check("ar_done", done0, 0);
    check("ar_result", res0, 0);
    check("ar_req", if0.alu_req, 0);
    check("ar_alu_ab", {if0.alu_a, if0.alu_b}, 0);
    check("ar_alu_op", if0.alu_op, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    run_op(32'd6, 32'd7, 0, d, d1, r, r1, rq, m, zb, sb, dp, b1);
    check("ar_new_done_cyc", d, 5);
    check("ar_new_result", r, 42);
    check("ar_new_reqs", rq, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
